// File: rtl/ab_stim_sequencer_pkg.sv
// Shared state encodings and default sizing for the (A,B) stimulus sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ab_stim_sequencer_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_HOLD  = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/ab_stim_sequencer_hold_counter.sv
// Loadable down-counter that times how long each (A,B) pair is held.
// Latency: load takes effect on the next edge; zero is decoded from the count register.
// Backpressure: none; en only gates the decrement, and the count sticks at zero.
// Ports: clock/RST, load (reload HOLD-1), en (decrement), zero (count == 0).
module ab_stim_sequencer_hold_counter #(
  parameter  int HOLD = 5,
  localparam int CW   = $clog2(HOLD + 1)
) (
  input  logic clock,
  input  logic RST,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ab_stim_sequencer.sv
// Plays a stored sequence of (A,B) pairs into a lab FSM, HOLD cycles each, logging y_in per step.
// Latency: start at edge E0 -> done pulse in the cycle after edge E(1 + len*HOLD).
// Backpressure: start and wr_en are ignored while busy; abort cancels a run on the next edge.
// Ports: wr_en/wr_addr/wr_data program slots; len/start/abort control a run;
//        A/B/fsm_rst drive the controlled FSM, y_in is its output;
//        busy/done/step/y_log report progress and captured results.
module ab_stim_sequencer
  import ab_stim_sequencer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int HOLD  = DEF_HOLD
) (
  input  logic             clock,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [1:0]       wr_data,
  input  logic [AW:0]      len,
  input  logic             start,
  input  logic             abort,
  input  logic             y_in,
  output logic             A,
  output logic             B,
  output logic             fsm_rst,
  output logic             busy,
  output logic             done,
  output logic [DEPTH-1:0] y_log,
  output logic [AW-1:0]    step
);

  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [AW:0]   len_q;
  logic [AW:0]   len_clamp;
  logic [AW-1:0] nxt_step;
  logic          last_step;
  logic          cnt_zero;
  logic          cnt_load;
  logic          wr_ok;

  assign len_clamp = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  assign nxt_step  = step + 1'b1;
  assign last_step = ({1'b0, step} == (len_q - 1'b1));
  // Pattern slots are only writable when no run is using them.
  assign wr_ok     = wr_en && ((state == S_IDLE) || (state == S_FIN));
  // Reload entering RUN and at every step boundary; a reload on the final
  // step or on abort is harmless because the counter is then unused.
  assign cnt_load  = (state == S_CLR) || ((state == S_RUN) && cnt_zero);

  ab_stim_sequencer_hold_counter #(.HOLD(HOLD)) u_hold (
    .clock (clock),
    .RST   (RST),
    .load  (cnt_load),
    .en    (state == S_RUN),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b00;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      A       <= 1'b0;
      B       <= 1'b0;
      fsm_rst <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      step    <= '0;
      y_log   <= '0;
      len_q   <= '0;
    end else begin
      fsm_rst <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              len_q   <= len_clamp;
              y_log   <= '0;
              step    <= '0;
              fsm_rst <= 1'b1;
              busy    <= 1'b1;
              state   <= S_CLR;
            end
          end
        end
        S_CLR: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            // A write on the start edge has landed by now, so slot 0 is current.
            {A, B} <= mem[0];
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            // Abort beats a terminal step: no capture, no done.
            state  <= S_IDLE;
            busy   <= 1'b0;
            {A, B} <= 2'b00;
          end else if (cnt_zero) begin
            y_log[step] <= y_in;
            if (last_step) begin
              state  <= S_FIN;
              done   <= 1'b1;
              busy   <= 1'b0;
              {A, B} <= 2'b00;
            end else begin
              step   <= nxt_step;
              {A, B} <= mem[nxt_step];
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ab_stim_sequencer.sv
module tb_ab_stim_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int HOLD  = 5;

  logic             clock = 1'b0;
  logic             RST   = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [1:0]       wr_data = '0;
  logic [AW:0]      len = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             y_in;
  logic             A, B, fsm_rst, busy, done;
  logic [DEPTH-1:0] y_log;
  logic [AW-1:0]    step;

  logic [1:0] exp_pat [DEPTH];

  int n_vec = 0;
  int n_bad = 0;

  ab_stim_sequencer #(.DEPTH(DEPTH), .AW(AW), .HOLD(HOLD)) dut (
    .clock   (clock),
    .RST     (RST),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .len     (len),
    .start   (start),
    .abort   (abort),
    .y_in    (y_in),
    .A       (A),
    .B       (B),
    .fsm_rst (fsm_rst),
    .busy    (busy),
    .done    (done),
    .y_log   (y_log),
    .step    (step)
  );

  // Stub controlled FSM.
  assign y_in = A & B;

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wr(input int a, input logic [1:0] d);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    exp_pat[a] = d;
  endtask

  // Start a run of n steps and check every cycle. abort_at / poke_at give the
  // run cycle at which abort, or start+wr_en(mem[1]=11), is driven (-1 = never).
  task automatic run_seq(input int n, input int abort_at, input int poke_at,
                         input logic [7:0] exp_y);
    bit stop;
    stop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr", {fsm_rst, busy, done, step, A, B}, {3'b110, 3'd0, 2'b00});
    for (int c = 0; c < n * HOLD && !stop; c++) begin
      if (c == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort", {fsm_rst, busy, done, A, B}, 5'b00000);
        stop = 1'b1;
      end else begin
        if (c == poke_at) begin
          start   = 1'b1;
          wr_en   = 1'b1;
          wr_addr = 3'd1;
          wr_data = 2'b11;
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        chk("run", {fsm_rst, busy, done, step, A, B},
            {3'b010, 3'(c / HOLD), exp_pat[c / HOLD]});
      end
    end
    if (stop) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("no_done", {busy, done, A, B}, 4'b0000);
      end
    end else begin
      tick();
      chk("fin", {fsm_rst, busy, done, A, B}, 5'b00100);
      tick();
      chk("idle", {busy, done}, 2'b00);
    end
    chk("y_log", y_log, exp_y);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_pat[i] = 2'b00;

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset", {A, B, fsm_rst, busy, done, step, y_log}, 0);
    RST = 1'b1;
    tick();

    // Basic three-step run
    wr(0, 2'b10);
    wr(1, 2'b00);
    wr(2, 2'b11);
    len = 4'd3;
    run_seq(3, -1, -1, 8'b00000100);

    // len = 0: immediate done, y_log untouched
    len   = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_fin", {fsm_rst, busy, done, A, B}, 5'b00100);
    tick();
    chk("len0_idle", {fsm_rst, busy, done}, 3'b000);
    chk("len0_ylog", y_log, 8'b00000100);

    // Abort during step 1; slot 0 = 11 so the step-0 capture is visible
    wr(0, 2'b11);
    len = 4'd3;
    run_seq(3, 7, -1, 8'b00000001);
    wr(0, 2'b10);

    // start + write while busy are ignored; rerun shows mem[1] unchanged
    run_seq(3, -1, 3, 8'b00000100);
    run_seq(3, -1, -1, 8'b00000100);

    // len = 9 clamps to all 8 slots
    wr(0, 2'b11); wr(1, 2'b01); wr(2, 2'b10); wr(3, 2'b11);
    wr(4, 2'b00); wr(5, 2'b11); wr(6, 2'b01); wr(7, 2'b11);
    len = 4'd9;
    run_seq(8, -1, -1, 8'b10101001);

    // Asynchronous reset mid-run (step 1, y_log[0] already captured)
    len   = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("pre_rst", {busy, step, y_log}, {1'b1, 3'd1, 8'b00000001});
    RST = 1'b0;
    #1;
    chk("rst_async", {A, B, fsm_rst, busy, done, step, y_log}, 0);
    @(negedge clock);
    RST = 1'b1;
    repeat (3) tick();
    chk("rst_no_resume", {A, B, fsm_rst, busy, done, step}, 0);
    for (int i = 0; i < DEPTH; i++) exp_pat[i] = 2'b00;
    run_seq(3, -1, -1, 8'b00000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
